// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampled, majority-voted UART receiver with a
// configurable frame and a VALID/READY output holding register.
module uart_rx_param #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_line,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int DIV =
    (CLK_HZ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW = $clog2(OVERSAMPLE);

  localparam logic [SW-1:0] S_LO   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_HI   = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DIV - 1);
  localparam logic [3:0]    B_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    P_LAST = 4'(STOP_BITS - 1);
  localparam logic          ODD    = (PARITY == 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic                 sync1;
  logic                 rx_s;
  logic                 rx_prev;
  logic [DW-1:0]        div_cnt;
  logic [SW-1:0]        smp_idx;
  logic [1:0]           smp;
  logic [2:0]           state;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 pe;
  logic                 fe;
  logic                 commit;
  logic                 tick;
  logic                 start_det;
  logic                 vote;
  logic                 maj;
  logic                 pop;

  assign tick = (div_cnt == D_LAST);
  // rx_prev must be high first, so a held-low line never restarts a frame
  assign start_det = (state == S_IDLE) && rx_prev && !rx_s;
  assign vote = tick && (smp_idx == S_HI);
  assign maj = (smp[1] & smp[0]) | (smp[1] & rx_s) | (smp[0] & rx_s);
  assign pop = valid && ready;
  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= rx_line;
      rx_s    <= sync1;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      smp_idx <= '0;
      smp     <= 2'b11;
    end else if (start_det) begin
      div_cnt <= '0;
      smp_idx <= '0;
    end else if (tick) begin
      div_cnt <= '0;
      smp_idx <= (smp_idx == S_LAST) ? '0 : smp_idx + SW'(1);
      if (smp_idx == S_LO || smp_idx == S_MID)
        smp <= {smp[0], rx_s};
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // Transitions happen at the third vote; smp_idx keeps bit phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      bit_idx <= '0;
      shreg   <= '0;
      pe      <= 1'b0;
      fe      <= 1'b0;
      commit  <= 1'b0;
    end else begin
      commit <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_det) begin
            state   <= S_START;
            bit_idx <= '0;
            pe      <= 1'b0;
            fe      <= 1'b0;
          end
        end
        S_START: begin
          if (vote)
            state <= maj ? S_IDLE : S_DATA;
        end
        S_DATA: begin
          if (vote) begin
            shreg <= {maj, shreg[DATA_BITS-1:1]};
            if (bit_idx == B_LAST) begin
              bit_idx <= '0;
              state   <= (PARITY != 0) ? S_PAR : S_STOP;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end
        end
        S_PAR: begin
          if (vote) begin
            pe    <= (^shreg) ^ maj ^ ODD;
            state <= S_STOP;
          end
        end
        S_STOP: begin
          if (vote) begin
            if (!maj)
              fe <= 1'b1;
            if (bit_idx == P_LAST) begin
              state  <= S_IDLE;
              commit <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (commit && valid && !ready)
        overrun <= 1'b1;
      else if (pop)
        overrun <= 1'b0;
      if (commit && (!valid || ready)) begin
        data       <= shreg;
        parity_err <= pe;
        frame_err  <= fe;
        valid      <= 1'b1;
      end else if (pop) begin
        valid      <= 1'b0;
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
      end
    end
  end

endmodule
